// File: rtl/e_mdu_sched_pkg.sv
// rtl/e_mdu_sched_pkg.sv - shared MD op codes, FSM states and latency defaults
package e_mdu_sched_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for a countdown
  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// rtl/e_mdu_arith.sv - combinational 64-bit mul/div result generation
module e_mdu_arith
  import e_mdu_sched_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_safe;
  logic               div_ovf;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  assign div_zero = (b == 32'd0);
  // INT_MIN / -1 overflows; dividing by 1 instead yields the wrapped quotient
  // (INT_MIN) and a zero remainder, and keeps the divider away from a zero divisor.
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_safe   = (div_zero || div_ovf) ? 32'd1 : b;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division truncates toward zero, so the remainder follows the dividend's sign
  assign q_s = $signed(a) / $signed(b_safe);
  assign r_s = $signed(a) % $signed(b_safe);
  assign q_u = a / b_safe;
  assign r_u = a % b_safe;

  // Select the {HI, LO} pair for the requested operation
  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      MD_MULT: begin
        hi = prod_s[63:32];
        lo = prod_s[31:0];
      end
      MD_MULTU: begin
        hi = prod_u[63:32];
        lo = prod_u[31:0];
      end
      MD_DIV: begin
        hi = r_s;
        lo = q_s;
      end
      MD_DIVU: begin
        hi = r_u;
        lo = q_u;
      end
      default: begin
        hi = 32'd0;
        lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu_sched.sv
// rtl/e_mdu_sched.sv - E-stage multiply/divide sequencing controller
module e_mdu_sched
  import e_mdu_sched_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic        E_start,
  output logic        E_busy,
  output logic        D_md_stall,
  output logic [31:0] E_md_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      shadow_hi;
  logic [31:0]      shadow_lo;
  logic             shadow_ok;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div_zero;
  logic             accept;
  logic             commit;

  e_mdu_arith u_arith (
    .op       (E_md_op),
    .a        (E_A),
    .b        (E_B),
    .hi       (res_hi),
    .lo       (res_lo),
    .div_zero (div_zero)
  );

  assign E_start    = is_start_op(E_md_op);
  assign E_busy     = (state_q == ST_RUN);
  assign D_md_stall = D_is_md & (E_start | E_busy);
  // Starts arriving while busy are protocol violations and are dropped
  assign accept     = (state_q == ST_IDLE) && E_start;
  assign commit     = (state_q == ST_RUN) && (cnt_q == CNT_ONE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> RUN on a start, RUN -> IDLE on the final countdown edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (E_start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_ONE) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Countdown: load the op's latency on start, decrement every edge while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= is_div_op(E_md_op) ? DIV_LOAD : MULT_LOAD;
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Shadow result captured at start; a zero divisor marks it unusable for commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_hi <= 32'd0;
      shadow_lo <= 32'd0;
      shadow_ok <= 1'b0;
    end else if (accept) begin
      if (is_div_op(E_md_op) && div_zero) begin
        shadow_ok <= 1'b0;
      end else begin
        shadow_hi <= res_hi;
        shadow_lo <= res_lo;
        shadow_ok <= 1'b1;
      end
    end
  end

  // Architectural HI/LO: commit from shadow at countdown end, MTHI/MTLO only when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (commit) begin
      if (shadow_ok) begin
        HI <= shadow_hi;
        LO <= shadow_lo;
      end
    end else if (state_q == ST_IDLE) begin
      if (E_md_op == MD_MTHI) HI <= E_A;
      if (E_md_op == MD_MTLO) LO <= E_A;
    end
  end

  // Move-from reads architectural state only, never the pending shadow
  always_comb begin
    E_md_out = 32'd0;
    case (E_md_op)
      MD_MFHI: E_md_out = HI;
      MD_MFLO: E_md_out = LO;
      default: E_md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu_sched.sv
// tb/tb_e_mdu_sched.sv - scoreboard bench for e_mdu_sched
module tb_e_mdu_sched;
  import e_mdu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_is_md;
  logic        E_start;
  logic        E_busy;
  logic        D_md_stall;
  logic [31:0] E_md_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];
  logic        busy_prev = 1'b0;

  always #5 clk = ~clk;

  e_mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_md_op    (E_md_op),
    .E_A        (E_A),
    .E_B        (E_B),
    .D_is_md    (D_is_md),
    .E_start    (E_start),
    .E_busy     (E_busy),
    .D_md_stall (D_md_stall),
    .E_md_out   (E_md_out),
    .HI         (HI),
    .LO         (LO)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: each busy falling edge is a commit; pop and compare {HI,LO}
  always @(negedge clk) begin
    if (E_busy && (E_start || E_md_op == MD_MTHI || E_md_op == MD_MTLO)) begin
      errors++;
      $display("FAIL protocol actual=op%0d_while_busy required=no_md_op", E_md_op);
    end
    if (busy_prev && !E_busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected actual=0x%0h required=none", {HI, LO});
      end else begin
        check(name_q.pop_front(), {HI, LO}, exp_q.pop_front());
      end
    end
    busy_prev = E_busy;
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_hilo, input int n_exp, input string nm);
    int n;
    exp_q.push_back(exp_hilo);
    name_q.push_back({nm, "_hilo"});
    @(posedge clk); #1;
    E_md_op = op; E_A = a; E_B = b; D_is_md = 1'b1;
    #3;
    check({nm, "_start_stall"}, {63'd0, D_md_stall}, 64'd1);
    @(posedge clk); #1;
    E_md_op = MD_NONE;
    n = 0;
    while (E_busy && n < 50) begin
      @(negedge clk);
      if (E_busy) begin
        n++;
        check({nm, "_busy_stall"}, {63'd0, D_md_stall}, 64'd1);
      end
    end
    check({nm, "_busy_cycles"}, 64'(n), 64'(n_exp));
    check({nm, "_stall_after"}, {63'd0, D_md_stall}, 64'd0);
  endtask

  task automatic mf_check(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
    @(posedge clk); #1;
    E_md_op = MD_MFHI;
    #2;
    check({nm, "_mfhi"}, {32'd0, E_md_out}, {32'd0, exp_hi});
    E_md_op = MD_MFLO;
    #1;
    check({nm, "_mflo"}, {32'd0, E_md_out}, {32'd0, exp_lo});
    E_md_op = MD_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; E_md_op = MD_NONE; E_A = 32'd0; E_B = 32'd0; D_is_md = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    @(posedge clk); #1;
    E_md_op = MD_MFHI; D_is_md = 1'b1;
    #2;
    check("rst_mfhi", {32'd0, E_md_out}, 64'd0);
    check("rst_busy", {63'd0, E_busy}, 64'd0);
    check("rst_stall", {63'd0, D_md_stall}, 64'd0);
    E_md_op = MD_MFLO;
    #1;
    check("rst_mflo", {32'd0, E_md_out}, 64'd0);
    E_md_op = MD_NONE;

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, "mult");
    mf_check(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");

    run_op(MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 10, "divu");
    mf_check(32'd2, 32'd14, "divu");

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, "div");
    run_op(MD_DIV, 32'd55, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, "div0");
    mf_check(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div0");

    run_op(MD_MULTU, 32'h0001_0000, 32'h0003_0000, {32'd3, 32'd0}, 5, "multu");

    @(posedge clk); #1;
    E_md_op = MD_MTHI; E_A = 32'h1234_5678;
    @(posedge clk); #1;
    E_md_op = MD_MFHI;
    #2;
    check("mthi_mfhi", {32'd0, E_md_out}, {32'd0, 32'h1234_5678});
    check("mthi_busy", {63'd0, E_busy}, 64'd0);
    @(posedge clk); #1;
    E_md_op = MD_MTLO; E_A = 32'hCAFE_F00D;
    @(posedge clk); #1;
    E_md_op = MD_MFLO;
    #2;
    check("mtlo_mflo", {32'd0, E_md_out}, {32'd0, 32'hCAFE_F00D});
    check("mtlo_hi_kept", {32'd0, HI}, {32'd0, 32'h1234_5678});
    E_md_op = MD_NONE;

    exp_q.push_back(64'd0);
    name_q.push_back("rst_mid_hilo");
    @(posedge clk); #1;
    E_md_op = MD_MULTU; E_A = 32'hFFFF_FFFF; E_B = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    E_md_op = MD_NONE;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, E_busy}, 64'd0);
    check("rst_mid_hi", {32'd0, HI}, 64'd0);
    check("rst_mid_lo", {32'd0, LO}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_hi", {32'd0, HI}, 64'd0);
    check("post_rst_lo", {32'd0, LO}, 64'd0);
    check("post_rst_busy", {63'd0, E_busy}, 64'd0);
    @(negedge clk); #1;
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
